// File: rtl/s2p_rx.sv
// Serial-to-parallel receiver for the MSB-first p2s link.
// Shifts LEN bits after an enable rising edge and presents the frame on a valid/ready register.
module s2p_rx #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 4,
    parameter int DELAY = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             enable,
    input  logic [LEN_W-1:0] len,
    output logic [WIDTH-1:0] data_out,
    output logic [LEN_W-1:0] rx_len,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             overrun,
    input  logic             clr_ovr,
    output logic             abort_err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SHIFT
    } state_t;

    localparam int DW = (DELAY > 1) ? $clog2(DELAY + 1) : 1;
    localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic             enable_d;
    logic [WIDTH-1:0] shreg;
    logic [LEN_W:0]   cnt;
    logic [LEN_W:0]   cnt_next;
    logic [LEN_W:0]   n;
    logic [LEN_W-1:0] len_q;
    logic [DW-1:0]    dcnt;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] assembled;

    // The word as it will look once this edge's bit is in, so completion can use it directly.
    always_comb begin
        bit_mask  = MSB_ONE >> cnt;
        assembled = serial_in ? (shreg | bit_mask) : (shreg & ~bit_mask);
        cnt_next  = cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            enable_d  <= 1'b0;
            shreg     <= '0;
            cnt       <= '0;
            n         <= '0;
            len_q     <= '0;
            dcnt      <= '0;
            data_out  <= '0;
            rx_len    <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            abort_err <= 1'b0;
        end else begin
            enable_d  <= enable;
            abort_err <= 1'b0;
            if (clr_ovr)
                overrun <= 1'b0;
            if (valid && ready)
                valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (enable && !enable_d) begin
                        n     <= (len == '0) ? (LEN_W+1)'(WIDTH) : {1'b0, len};
                        len_q <= len;
                        shreg <= '0;
                        cnt   <= '0;
                        dcnt  <= '0;
                        busy  <= 1'b1;
                        state <= (DELAY > 0) ? WAIT : SHIFT;
                    end
                end
                WAIT: begin
                    if (!enable) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        abort_err <= 1'b1;
                    end else if (dcnt == DW'(DELAY - 1)) begin
                        state <= SHIFT;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                SHIFT: begin
                    // A dropped enable wins even on the last sample edge.
                    if (!enable) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        abort_err <= 1'b1;
                    end else begin
                        shreg <= assembled;
                        cnt   <= cnt_next;
                        if (cnt_next == n) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (!valid || ready) begin
                                data_out <= assembled;
                                rx_len   <= len_q;
                                valid    <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_s2p_rx.sv
// Testbench for s2p_rx: directed link scenarios plus random frames, checked by a
// scoreboard of expected MSB-aligned words popped whenever the receiver hands a frame over.
module tb_s2p_rx;

    localparam int WIDTH = 16;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             serial_in = 1'b0;
    logic             enable = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic [WIDTH-1:0] data_out;
    logic [LEN_W-1:0] rx_len;
    logic             valid;
    logic             ready = 1'b0;
    logic             busy;
    logic             overrun;
    logic             clr_ovr = 1'b0;
    logic             abort_err;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [LEN_W-1:0] len;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   hold_ready = 1'b1;
    bit   rand_ready = 1'b0;

    s2p_rx #(.WIDTH(WIDTH), .LEN_W(LEN_W), .DELAY(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .serial_in (serial_in),
        .enable    (enable),
        .len       (len),
        .data_out  (data_out),
        .rx_len    (rx_len),
        .valid     (valid),
        .ready     (ready),
        .busy      (busy),
        .overrun   (overrun),
        .clr_ovr   (clr_ovr),
        .abort_err (abort_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Consumer side: ready is decided just after each rising edge and held through the next one.
    always @(posedge clk) begin
        #2;
        if (hold_ready)
            ready = 1'b0;
        else if (rand_ready)
            ready = 1'($urandom_range(0, 1));
        else
            ready = 1'b1;
    end

    // Monitor: a frame is handed over at the edge following a negedge that sees valid && ready.
    always @(negedge clk) begin
        if (!reset && valid && ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("[TB] FAIL unexpected_frame: got %h expected none", data_out);
            end else begin
                exp_t e;
                e = q.pop_front();
                checkOutput("frame_data", 32'(data_out), 32'(e.data));
                checkOutput("frame_len", 32'(rx_len), 32'(e.len));
            end
        end
    end

    function automatic logic [WIDTH-1:0] alignWord(input int lenv, input logic [WIDTH-1:0] word);
        int nb;
        logic [WIDTH-1:0] m;
        nb = (lenv == 0) ? WIDTH : lenv;
        m  = '1;
        m  = m << (WIDTH - nb);
        return word & m;
    endfunction

    task automatic idle(input int cycles);
        enable = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            serial_in = 1'($urandom_range(0, 1));
            len       = LEN_W'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    // Drives nsend bits MSB-first; returns just after the last sample edge with enable still high.
    task automatic applyStimulus(input int lenv, input logic [WIDTH-1:0] word, input int nsend,
                                 input bit push, input bit release_last, input bit chk_early);
        len    = LEN_W'(lenv);
        enable = 1'b1;
        @(posedge clk);
        #1;
        len = LEN_W'($urandom);
        for (int k = 0; k < nsend; k++) begin
            serial_in = word[WIDTH-1-k];
            if (k == nsend - 1) begin
                if (release_last)
                    hold_ready = 1'b0;
                if (chk_early)
                    checkOutput("valid_before_last", 32'(valid), 32'd0);
            end
            @(posedge clk);
            #1;
        end
        if (push)
            q.push_back('{data: alignWord(lenv, word), len: LEN_W'(lenv)});
    endtask

    task automatic waitDrain();
        int i;
        i = 0;
        while (q.size() != 0 && i < 400) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        int lenv;
        int nb;
        int nsend;
        logic [WIDTH-1:0] w;

        #2 reset = 1'b1;
        #1;
        checkOutput("reset_data", 32'(data_out), 32'd0);
        checkOutput("reset_rx_len", 32'(rx_len), 32'd0);
        checkOutput("reset_valid", 32'(valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_overrun", 32'(overrun), 32'd0);
        checkOutput("reset_abort", 32'(abort_err), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        idle(2);

        // 8-bit frame 0xA5 with junk below the frame that must be masked off
        hold_ready = 1'b1;
        applyStimulus(8, 16'hA53F, 8, 1'b1, 1'b0, 1'b1);
        checkOutput("a5_valid", 32'(valid), 32'd1);
        checkOutput("a5_busy", 32'(busy), 32'd0);
        checkOutput("a5_data", 32'(data_out), 32'h0000A500);
        checkOutput("a5_rx_len", 32'(rx_len), 32'd8);
        idle(3);
        checkOutput("a5_valid_held", 32'(valid), 32'd1);
        checkOutput("a5_data_held", 32'(data_out), 32'h0000A500);
        hold_ready = 1'b0;
        waitDrain();
        checkOutput("a5_valid_cleared", 32'(valid), 32'd0);

        // len=0 means full width
        hold_ready = 1'b1;
        idle(1);
        applyStimulus(0, 16'h1234, 16, 1'b1, 1'b0, 1'b1);
        checkOutput("w16_busy", 32'(busy), 32'd0);
        checkOutput("w16_data", 32'(data_out), 32'h00001234);
        checkOutput("w16_rx_len", 32'(rx_len), 32'd0);
        hold_ready = 1'b0;
        idle(1);
        waitDrain();

        // Overrun: second frame arrives while the first is still unconsumed
        hold_ready = 1'b1;
        idle(1);
        applyStimulus(8, 16'h3C00, 8, 1'b1, 1'b0, 1'b0);
        idle(2);
        checkOutput("pre_ovr", 32'(overrun), 32'd0);
        applyStimulus(8, 16'hFF00, 8, 1'b0, 1'b0, 1'b0);
        checkOutput("ovr_set", 32'(overrun), 32'd1);
        checkOutput("ovr_data_kept", 32'(data_out), 32'h00003C00);
        idle(2);
        checkOutput("ovr_sticky", 32'(overrun), 32'd1);
        clr_ovr = 1'b1;
        @(posedge clk);
        #1 clr_ovr = 1'b0;
        checkOutput("ovr_cleared", 32'(overrun), 32'd0);
        hold_ready = 1'b0;
        waitDrain();

        // Abort after 5 of 12 bits while a frame sits in the output register
        hold_ready = 1'b1;
        idle(1);
        applyStimulus(4, 16'h5000, 4, 1'b1, 1'b0, 1'b0);
        idle(2);
        applyStimulus(12, 16'($urandom), 5, 1'b0, 1'b0, 1'b0);
        checkOutput("abort_busy_mid", 32'(busy), 32'd1);
        idle(1);
        checkOutput("abort_pulse", 32'(abort_err), 32'd1);
        checkOutput("abort_valid_kept", 32'(valid), 32'd1);
        checkOutput("abort_data_kept", 32'(data_out), 32'h00005000);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        idle(1);
        checkOutput("abort_one_cycle", 32'(abort_err), 32'd0);
        hold_ready = 1'b0;
        waitDrain();
        idle(1);
        applyStimulus(12, 16'hABCF, 12, 1'b1, 1'b0, 1'b0);
        checkOutput("abc_data", 32'(data_out), 32'h0000ABC0);
        idle(1);
        waitDrain();

        // Enable dropping on the last sample edge is an abort
        applyStimulus(8, 16'h7700, 7, 1'b0, 1'b0, 1'b0);
        idle(1);
        checkOutput("last_edge_abort", 32'(abort_err), 32'd1);
        idle(3);
        checkOutput("last_edge_no_valid", 32'(valid), 32'd0);

        // Accept and completion on the same edge
        hold_ready = 1'b1;
        applyStimulus(8, 16'h1100, 8, 1'b1, 1'b0, 1'b0);
        idle(2);
        applyStimulus(8, 16'hE700, 8, 1'b1, 1'b1, 1'b0);
        checkOutput("simul_valid", 32'(valid), 32'd1);
        checkOutput("simul_data", 32'(data_out), 32'h0000E700);
        checkOutput("simul_no_ovr", 32'(overrun), 32'd0);
        idle(1);
        waitDrain();

        // Reset in the middle of a frame
        hold_ready = 1'b1;
        idle(1);
        applyStimulus(8, 16'($urandom), 3, 1'b0, 1'b0, 1'b0);
        reset  = 1'b1;
        enable = 1'b0;
        #1;
        checkOutput("midrst_data", 32'(data_out), 32'd0);
        checkOutput("midrst_valid", 32'(valid), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_rx_len", 32'(rx_len), 32'd0);
        checkOutput("midrst_abort", 32'(abort_err), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        hold_ready = 1'b0;
        idle(2);
        applyStimulus(4, 16'h9000, 4, 1'b1, 1'b0, 1'b0);
        checkOutput("postrst_data", 32'(data_out), 32'h00009000);
        idle(1);
        waitDrain();

        // Random frames with a stalling consumer and occasional aborts
        rand_ready = 1'b1;
        for (int f = 0; f < 60; f++) begin
            lenv = $urandom_range(0, 15);
            nb   = (lenv == 0) ? WIDTH : lenv;
            w    = 16'($urandom);
            if (nb > 1 && $urandom_range(0, 4) == 0) begin
                nsend = $urandom_range(1, nb - 1);
                applyStimulus(lenv, w, nsend, 1'b0, 1'b0, 1'b0);
                idle(1);
                checkOutput("rand_abort", 32'(abort_err), 32'd1);
            end else begin
                applyStimulus(lenv, w, nb, 1'b1, 1'b0, 1'b0);
            end
            idle($urandom_range(1, 3));
            waitDrain();
        end
        idle(4);
        checkOutput("rand_no_ovr", 32'(overrun), 32'd0);
        checkOutput("rand_queue_empty", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
